mmio_uart_tx: RTL and testbench

- Memory-mapped serial transmitter on the CPU external bus (a, d, oe, we), downstream of the CPU core.
- The CPU writes bytes into a small FIFO. A shifter sends each byte as 8N1, LSB first, on txd.
- A status register lets firmware poll for space and idle.
- The block is clocked on nclk, the same edge the CPU uses to commit register writes.

---
 rtl/mmio_uart_pkg.sv | 11 +
 rtl/sync_fifo.sv | 33 +++
 rtl/mmio_uart_tx.sv | 101 ++++++++++
 tb/tb_mmio_uart_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: shared state encoding, register offsets and bit indices for mmio_uart_tx
package mmio_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int CT_IRQ_EN = 0;
  localparam int CT_OVF_CLR = 7;
  localparam logic [15:0] OFF_DATA = 16'd0;
  localparam logic [15:0] OFF_CTRL = 16'd1;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-2 deep FIFO with wrap-bit pointers; full is judged before a same-cycle pop
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             nclk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_do_push;
  assign o_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_empty = r_wr == r_rd;
  assign o_dout = r_mem[r_rd[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  always_ff @(posedge nclk or negedge rst)
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
      if (i_pop && !o_empty) r_rd <= r_rd + (AW+1)'(1);
    end
  always_ff @(posedge nclk)
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: bus-mapped 8N1 UART transmitter with a byte FIFO and status/control registers.
// Define MMIO_UART_IRQ_EN to build the drained-transmitter interrupt and its enable bit.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int DEPTH = 4,
  parameter int BAUD_DIV = 16
) (
  input  logic        nclk,
  input  logic        rst,
  input  logic [15:0] a,
  inout  wire  [7:0]  d,
  input  logic        oe,
  input  logic        we,
  output logic        txd,
  output logic        irq_n
);
  localparam int DW = $clog2(BAUD_DIV);
  state_t r_state;
  logic r_we_q, r_ovf, r_txd;
  logic [DW-1:0] r_div;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shreg;
  logic w_sel0, w_sel1, w_wr, w_push, w_pop, w_full, w_empty, w_tick, w_busy, w_irq_en;
  logic [7:0] w_dout, w_status, w_ctrl;
  assign w_sel0 = a == BASE_ADDR + OFF_DATA;
  assign w_sel1 = a == BASE_ADDR + OFF_CTRL;
  assign w_wr = !we && r_we_q;
  assign w_push = w_wr && w_sel0;
  assign w_pop = r_state == IDLE && !w_empty;
  assign w_tick = r_div == DW'(BAUD_DIV - 1);
  assign w_busy = r_state != IDLE || !w_empty;
  assign txd = r_txd;
  always_comb begin
    w_status = '0;
    w_status[ST_BUSY] = w_busy;
    w_status[ST_FULL] = w_full;
    w_status[ST_OVF] = r_ovf;
    w_ctrl = '0;
    w_ctrl[CT_IRQ_EN] = w_irq_en;
  end
  assign d = (!oe && w_sel0) ? w_status : (!oe && w_sel1) ? w_ctrl : 8'bz;
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .nclk(nclk),
    .rst(rst),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_din(d),
    .o_dout(w_dout),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  // txd is a registered image of the state, so every phase is shifted by one cycle
  always_ff @(posedge nclk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_txd <= 1'b1;
      r_we_q <= 1'b1;
      r_ovf <= 1'b0;
      r_div <= '0;
      r_bitcnt <= '0;
      r_shreg <= '0;
    end else begin
      r_we_q <= we;
      if (w_push && w_full) r_ovf <= 1'b1;
      else if (w_wr && w_sel1 && d[CT_OVF_CLR]) r_ovf <= 1'b0;
      r_txd <= (r_state == START) ? 1'b0 : (r_state == DATA) ? r_shreg[0] : 1'b1;
      r_div <= (r_state == IDLE || w_tick) ? '0 : r_div + DW'(1);
      case (r_state)
        IDLE: if (!w_empty) begin
          r_shreg <= w_dout;
          r_bitcnt <= '0;
          r_state <= START;
        end
        START: if (w_tick) r_state <= DATA;
        DATA: if (w_tick) begin
          r_shreg <= r_shreg >> 1;
          r_bitcnt <= r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) r_state <= STOP;
        end
        STOP: if (w_tick) r_state <= IDLE;
      endcase
    end
`ifdef MMIO_UART_IRQ_EN
  logic r_irq_en, r_irq_n;
  assign w_irq_en = r_irq_en;
  assign irq_n = r_irq_n;
  always_ff @(posedge nclk or negedge rst)
    if (!rst) begin
      r_irq_en <= 1'b0;
      r_irq_n <= 1'b1;
    end else begin
      if (w_wr && w_sel1) r_irq_en <= d[CT_IRQ_EN];
      r_irq_n <= !(r_irq_en && w_empty && r_state == IDLE);
    end
`else
  assign w_irq_en = 1'b0;
  assign irq_n = 1'b1;
`endif
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: random bus traffic against a cycle-arithmetic model, with a UART receiver on txd
module tb_mmio_uart_tx;
  localparam int B = 16;
  localparam int DEP = 4;
  localparam int FR = 10 * B;
  logic nclk = 0, rst = 0, oe = 1, we = 1, drv = 0;
  logic [15:0] a = 16'h0000;
  logic [7:0] dq = 8'h00;
  wire [7:0] d;
  logic txd, irq_n;
  assign d = drv ? dq : 8'bz;
  always #5 nclk = ~nclk;
  mmio_uart_tx #(.BASE_ADDR(16'hFF00), .DEPTH(DEP), .BAUD_DIV(B)) dut (
    .nclk(nclk), .rst(rst), .a(a), .d(d), .oe(oe), .we(we), .txd(txd), .irq_n(irq_n)
  );
  int cyc = 0;
  always @(posedge nclk) cyc <= cyc + 1;
  int n_chk = 0, n_err = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  // model: each accepted byte is a (push edge, pop edge) pair; the rest follows by counting
  int pu[$], po[$];
  int last_pop = -1000;
  bit m_ovf = 0, m_irq = 0;
  logic [7:0] exp_b[$], rx_b[$];
  int exp_f[$], rx_f[$];
  function automatic int occ(int c);
    int n = 0;
    foreach (pu[i]) if (pu[i] <= c && po[i] > c) n++;
    return n;
  endfunction
  function automatic bit busy_at(int c);
    foreach (pu[i]) if (pu[i] <= c && c < po[i] + FR) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic [7:0] st_model(int c);
    return {5'b0, m_ovf, occ(c) == DEP, busy_at(c)};
  endfunction
  task automatic model_wr(logic [15:0] ad, logic [7:0] v, int e);
    int p;
    if (ad == 16'hFF00) begin
      if (occ(e - 1) == DEP) m_ovf = 1'b1;
      else begin
        p = (e + 1 > last_pop + FR + 1) ? e + 1 : last_pop + FR + 1;
        last_pop = p;
        pu.push_back(e);
        po.push_back(p);
        exp_b.push_back(v);
        exp_f.push_back(p + 1);
      end
    end else if (ad == 16'hFF01) begin
      if (v[7]) m_ovf = 1'b0;
`ifdef MMIO_UART_IRQ_EN
      m_irq = v[0];
`endif
    end
  endtask
  task automatic model_clear();
    pu.delete(); po.delete(); exp_b.delete(); exp_f.delete(); rx_b.delete(); rx_f.delete();
    last_pop = -1000;
    m_ovf = 1'b0;
    m_irq = 1'b0;
  endtask
  task automatic wr(logic [15:0] ad, logic [7:0] v, int n = 1);
    @(negedge nclk);
    a = ad; dq = v; drv = 1; we = 0;
    model_wr(ad, v, cyc + 1);
    repeat (n) @(negedge nclk);
    we = 1; drv = 0;
  endtask
  task automatic rd(logic [15:0] ad, string tag, logic [7:0] exp);
    @(negedge nclk);
    a = ad; oe = 0;
    #1 chk(tag, d, exp);
    oe = 1;
  endtask
  task automatic rd_st(string tag);
    @(negedge nclk);
    a = 16'hFF00; oe = 0;
    #1 chk(tag, d, st_model(cyc));
    oe = 1;
  endtask
  task automatic drain();
    int tgt;
    tgt = last_pop + FR + 20;
    while (cyc < tgt) @(negedge nclk);
    chk("nrx", rx_b.size(), exp_b.size());
    chk("nfall", rx_f.size(), exp_f.size());
    foreach (exp_b[i]) if (i < rx_b.size() && i < rx_f.size()) begin
      chk("byte", rx_b[i], exp_b[i]);
      chk("fall", rx_f[i], exp_f[i]);
    end
    exp_b.delete(); exp_f.delete(); rx_b.delete(); rx_f.delete();
  endtask
  // receiver: detect start edge, sample mid-bit, LSB first
  int mcnt = 0;
  bit mact = 0, mprev = 1;
  logic [7:0] msh = 8'h00;
  always @(negedge nclk) begin
    if (!rst) begin
      mact <= 0;
      mprev <= 1;
    end else begin
      mprev <= txd;
      if (!mact) begin
        if (mprev && !txd) begin
          mact <= 1;
          mcnt <= 1;
          rx_f.push_back(cyc);
        end
      end else begin
        mcnt <= mcnt + 1;
        if (mcnt == 8) chk("start", txd, 1'b0);
        else if (mcnt > 8 && mcnt < 152 && (mcnt - 8) % 16 == 0) msh <= {txd, msh[7:1]};
        else if (mcnt == 152) begin
          chk("stop", txd, 1'b1);
          rx_b.push_back(msh);
          mact <= 0;
        end
      end
    end
  end
  initial begin
    repeat (3) @(negedge nclk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_irq", irq_n, 1'b1);
    rst = 1;
    rd(16'hFF00, "st_idle", 8'h00);
    rd(16'hFF01, "ctrl_idle", 8'h00);
    wr(16'hFF00, 8'hA5);
    repeat (20) @(negedge nclk);
    rd(16'hFF00, "st_busy", 8'h01);
    rd_st("st_mid");
    drain();
    rd(16'hFF00, "st_done", 8'h00);
    for (int i = 0; i < 6; i++) wr(16'hFF00, 8'h10 + 8'(i));
    rd(16'hFF00, "st_ovf", 8'h07);
    rd_st("st_ovf_m");
    drain();
    rd(16'hFF00, "st_ovf_drained", 8'h04);
    wr(16'hFF01, 8'h80);
    rd(16'hFF00, "st_ovf_clr", 8'h00);
    wr(16'hFF00, 8'h3C, 5);
    drain();
    for (int r = 0; r < 10; r++) begin
      for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
        if ($urandom_range(0, 7) == 0) wr(16'hFF01, 8'($urandom) & 8'h80);
        else wr(16'hFF00, 8'($urandom));
        repeat ($urandom_range(0, 3)) @(negedge nclk);
        rd_st("st_rand");
      end
      repeat ($urandom_range(0, 200)) @(negedge nclk);
      rd_st("st_gap");
    end
    drain();
    rd_st("st_rand_end");
`ifdef MMIO_UART_IRQ_EN
    wr(16'hFF01, 8'h01);
    rd(16'hFF01, "ctrl_irq", 8'h01);
    repeat (2) @(negedge nclk);
    chk("irq_idle", irq_n, 1'b0);
    wr(16'hFF00, 8'h5A);
    repeat (30) @(negedge nclk);
    chk("irq_frame", irq_n, 1'b1);
    while (cyc < last_pop + FR) @(negedge nclk);
    chk("irq_stop", irq_n, 1'b1);
    @(negedge nclk);
    chk("irq_drained", irq_n, 1'b0);
    drain();
    wr(16'hFF01, 8'h00);
    repeat (2) @(negedge nclk);
    chk("irq_off", irq_n, 1'b1);
`else
    wr(16'hFF01, 8'h01);
    rd(16'hFF01, "ctrl_noirq", 8'h00);
    wr(16'hFF00, 8'h5A);
    drain();
    chk("irq_tied", irq_n, 1'b1);
`endif
    wr(16'hFF00, 8'hC3);
    wr(16'hFF00, 8'h96);
    while (cyc < exp_f[0] + 72) @(negedge nclk);
    chk("txd_bit3", txd, 1'b0);
    @(negedge nclk);
    rst = 0;
    #1 chk("rst_mid_txd", txd, 1'b1);
    chk("rst_mid_irq", irq_n, 1'b1);
    model_clear();
    repeat (3) @(negedge nclk);
    rst = 1;
    rd_st("st_after_rst");
    rd(16'hFF01, "ctrl_after_rst", 8'h00);
    repeat (400) @(negedge nclk);
    chk("no_frames", rx_f.size(), 0);
    chk("no_bytes", rx_b.size(), 0);
    chk("txd_quiet", txd, 1'b1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
